// File: rtl/spart_core_if.sv
// spart_core_if: processor-side bus handshake between the bus driver and spart_core.
// The shared 8-bit databus stays a plain inout pin on the core.
interface spart_core_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_core.sv
// spart_core: bus-attached 8N1 UART with a 16-bit divisor and 16x oversampled baud enable.
// Define SPART_LOOPBACK_EN to feed the receiver from the internal txd instead of rxd.
module spart_core #(
    parameter logic [15:0] DIV_RESET   = 16'd325,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spart_core_if.slave bus,
    inout  wire  [7:0]  databus,
    output logic        txd,
    input  logic        rxd
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] A_BUF  = 2'b00;
    localparam logic [1:0] A_STAT = 2'b01;
    localparam logic [1:0] A_DBL  = 2'b10;
    localparam logic [1:0] A_DBH  = 2'b11;

    logic        wr_s, rd_s, tx_load_s, rd_buf_s, rd_stat_s;
    logic [7:0]  wdata_s, rdata_s;
    logic [15:0] div_r, div_nxt_s, baud_cnt_r;
    logic        div_wr_s, en_s;

    logic [1:0]  tx_state_r;
    logic [3:0]  tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        txd_r, tbr_r;

    logic [SYNC_STAGES-1:0] sync_r;
    logic        sync_rx_s;
    logic [1:0]  rx_state_r;
    logic [3:0]  rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r, rx_buf_r;
    logic        rda_r, fe_r, ovr_r;

    assign wr_s      = bus.iocs & ~bus.iorw;
    assign rd_s      = bus.iocs &  bus.iorw;
    assign wdata_s   = databus;
    assign tx_load_s = wr_s && (bus.ioaddr == A_BUF) && tbr_r;
    assign rd_buf_s  = rd_s && (bus.ioaddr == A_BUF);
    assign rd_stat_s = rd_s && (bus.ioaddr == A_STAT);

    assign databus = rd_s ? rdata_s : 8'bzzzz_zzzz;
    assign txd     = txd_r;
    assign bus.tbr = tbr_r;
    assign bus.rda = rda_r;

    // Read data mux for the register currently addressed.
    always_comb begin
        rdata_s = 8'h00;
        case (bus.ioaddr)
            A_BUF:   rdata_s = rx_buf_r;
            A_STAT:  rdata_s = {4'b0000, ovr_r, fe_r, tbr_r, rda_r};
            A_DBL:   rdata_s = div_r[7:0];
            A_DBH:   rdata_s = div_r[15:8];
            default: rdata_s = 8'h00;
        endcase
    end

    // Next divisor value and write strobe from a divisor-byte bus write.
    always_comb begin
        div_nxt_s = div_r;
        div_wr_s  = 1'b0;
        if (wr_s) begin
            case (bus.ioaddr)
                A_DBL: begin
                    div_nxt_s = {div_r[15:8], wdata_s};
                    div_wr_s  = 1'b1;
                end
                A_DBH: begin
                    div_nxt_s = {wdata_s, div_r[7:0]};
                    div_wr_s  = 1'b1;
                end
                default: begin
                    div_nxt_s = div_r;
                    div_wr_s  = 1'b0;
                end
            endcase
        end else begin
            div_nxt_s = div_r;
            div_wr_s  = 1'b0;
        end
    end

    // Divisors of 0 or 1 are treated as "baud generator stopped".
    assign en_s = (div_r > 16'd1) && (baud_cnt_r == 16'd1);

    // Divisor register and down-counting baud timer; a divisor write restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r      <= DIV_RESET;
            baud_cnt_r <= DIV_RESET;
        end else if (div_wr_s) begin
            div_r      <= div_nxt_s;
            baud_cnt_r <= div_nxt_s;
        end else if (div_r <= 16'd1) begin
            baud_cnt_r <= baud_cnt_r;
        end else if (baud_cnt_r <= 16'd1) begin
            baud_cnt_r <= div_r;
        end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
        end
    end

    // Transmitter: IDLE with tbr low means a byte is waiting for the next en pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
            tbr_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    if (tx_load_s) begin
                        tx_shift_r <= wdata_s;
                        tbr_r      <= 1'b0;
                    end else if (!tbr_r && en_s) begin
                        tx_state_r <= ST_START;
                        tx_cnt_r   <= 4'd0;
                        txd_r      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (en_s && tx_cnt_r == 4'd15) begin
                        tx_state_r <= ST_DATA;
                        tx_cnt_r   <= 4'd0;
                        tx_bit_r   <= 3'd0;
                        txd_r      <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                    end else if (en_s) begin
                        tx_cnt_r <= tx_cnt_r + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (en_s && tx_cnt_r == 4'd15) begin
                        tx_cnt_r <= 4'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= ST_STOP;
                            txd_r      <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            txd_r      <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else if (en_s) begin
                        tx_cnt_r <= tx_cnt_r + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (en_s && tx_cnt_r == 4'd15) begin
                        tx_state_r <= ST_IDLE;
                        tx_cnt_r   <= 4'd0;
                        tbr_r      <= 1'b1;
                    end else if (en_s) begin
                        tx_cnt_r <= tx_cnt_r + 4'd1;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    txd_r      <= 1'b1;
                    tbr_r      <= 1'b1;
                end
            endcase
        end
    end

    // rxd synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef SPART_LOOPBACK_EN
    assign sync_rx_s = txd_r;
`else
    assign sync_rx_s = sync_r[SYNC_STAGES-1];
`endif

    // Receiver FSM and status flags; clears come first so a same-edge set overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_buf_r   <= 8'h00;
            rda_r      <= 1'b0;
            fe_r       <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            if (rd_buf_s) begin
                rda_r <= 1'b0;
            end
            if (rd_stat_s) begin
                fe_r  <= 1'b0;
                ovr_r <= 1'b0;
            end
            case (rx_state_r)
                ST_IDLE: begin
                    if (en_s && !sync_rx_s) begin
                        rx_state_r <= ST_START;
                        rx_cnt_r   <= 4'd0;
                    end
                end
                ST_START: begin
                    if (en_s && rx_cnt_r == 4'd7) begin
                        rx_cnt_r   <= 4'd0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= sync_rx_s ? ST_IDLE : ST_DATA;
                    end else if (en_s) begin
                        rx_cnt_r <= rx_cnt_r + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (en_s && rx_cnt_r == 4'd15) begin
                        rx_cnt_r   <= 4'd0;
                        rx_shift_r <= {sync_rx_s, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else if (en_s) begin
                        rx_cnt_r <= rx_cnt_r + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (en_s && rx_cnt_r == 4'd15) begin
                        rx_state_r <= ST_IDLE;
                        rx_cnt_r   <= 4'd0;
                        if (sync_rx_s) begin
                            rx_buf_r <= rx_shift_r;
                            rda_r    <= 1'b1;
                            if (rda_r) begin
                                ovr_r <= 1'b1;
                            end
                        end else begin
                            fe_r <= 1'b1;
                        end
                    end else if (en_s) begin
                        rx_cnt_r <= rx_cnt_r + 4'd1;
                    end
                end
                default: begin
                    rx_state_r <= ST_IDLE;
                    rx_cnt_r   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Bus-attached UART (SPART) that sits directly downstream of the processor-side bus driver and consumes its iocs/iorw/ioaddr/databus transactions.
- Contains four parts: bus decode, a 16-bit programmable divisor with a 16x oversample baud enable generator, a transmitter, and a receiver.
- Reports transmit-ready (tbr) and receive-data-available (rda) back to the driver.
- Frame format is fixed 8N1, LSB first.

Parameters:
- DIV_RESET, 16'd325: divisor loaded at reset (4800 baud at 25 MHz with 16x oversampling).
- SYNC_STAGES, 2: number of flip-flop stages on rxd before the receiver uses it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- iocs  in  1  chip select.
- iorw  in  1  direction: 1 = read, 0 = write.
- ioaddr  in  2  register select: 00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- databus  inout  8  shared data bus.
- rda  out  1  receive buffer holds an unread byte.
- tbr  out  1  transmitter ready to accept a byte.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous to clk.

Behaviour:
- Reset values: txd=1, tbr=1, rda=0, rx_buf=0, status error bits=0, divisor=DIV_RESET, baud counter=DIV_RESET, TX and RX state machines in IDLE, databus released (Z).
- Write capture: on the clk edge where iocs=1 and iorw=0, the databus value is captured.
  - Addr 10 writes divisor[7:0]; addr 11 writes divisor[15:8].
  - Either divisor write also reloads the baud counter with the new full divisor in the same cycle.
  - Addr 01 writes are ignored.
- Read drive: databus is driven combinationally only while iocs=1 and iorw=1; it is Z otherwise.
  - Addr 00 returns rx_buf.
  - Addr 01 returns {4'b0, ovr, fe, tbr, rda}.
  - Addr 10 / 11 return the divisor low / high byte.
- Baud generator: the counter decrements every clk.
  - When the count equals 1, it asserts a one-cycle en pulse and reloads the divisor. The en period is therefore exactly divisor clocks.
  - divisor=0 or 1: no en pulses; the counter holds.
- Transmitter FSM, states IDLE → START → DATA → STOP → IDLE, 16 en pulses per bit:
  - A write to addr 00 while tbr=1 latches the byte; tbr=0 from the next cycle.
  - The first bit starts on the next en pulse: txd=0 for START, then 8 data bits LSB first, then txd=1 for STOP.
  - After the 16th en pulse of STOP: return to IDLE and set tbr=1.
  - A write to addr 00 while tbr=0 is ignored and the byte is lost.
- Receiver FSM, states IDLE → START → DATA → STOP → IDLE, on the synchronized rxd (sync_rx):
  - IDLE: sync_rx=0 sampled on en → START; clear the en-pulse count.
  - START: re-check sync_rx on the 8th en pulse (bit centre). If 1, treat as a false start and return to IDLE; if 0, go to DATA.
  - DATA: sample every 16 en pulses; shift LSB first, 8 bits.
  - STOP: sample after 16 en pulses. If 1, load rx_buf and set rda. If 0, set fe, discard the byte, leave rda unchanged. Return to IDLE.
- Overrun: if a good byte completes while rda=1, rx_buf is overwritten, ovr=1, and rda stays 1.
- Read side effects:
  - An addr 00 read clears rda on the next edge.
  - An addr 01 read clears fe and ovr on the next edge.
  - If a set event and a clear event land on the same edge, the set wins.
- A divisor write mid-frame takes effect immediately; the current frame is corrupted and this is not flagged.
- Synchronous rst mid-frame aborts both FSMs: txd=1 on the next edge and all reset values apply.

Optional Feature:
- Macro SPART_LOOPBACK_EN.
- Defined: the receiver input is taken from the internal txd (no synchronizer delay required); txd is still driven to the pin and rxd is ignored.
- Undefined: the receiver uses rxd through the SYNC_STAGES synchronizer.

Test Plan:
- Reset then read each register → addr 10 = 0x45, addr 11 = 0x01, addr 01 = 0x02; txd=1, rda=0.
- Write divisor 0x0004, then write 0x55 to addr 00 → tbr falls the next cycle. txd carries start bit, 1,0,1,0,1,0,1,0, then stop; each bit lasts 64 clocks; tbr rises about 640 clocks after the first en pulse.
- Drive rxd with 0xA3 frames at 64 clocks/bit (divisor 4) → rda=1 after the stop bit, addr 00 reads 0xA3, rda=0 on the next cycle.
- Send two frames without reading, then read status → 0x03 with ovr=1 (0x0B); the subsequent addr 00 read returns the second byte.
- Drive a 0xC1 frame with stop bit = 0 → fe=1, rda=0; a 1-cycle-wide-in-bit glitch low on idle rxd (under 8 en pulses) → no reception, FSM back in IDLE.
- Build with SPART_LOOPBACK_EN, write 0x7E → rda=1 about 640 clocks later, rx_buf=0x7E. Assert rst mid-transmit → txd=1 and tbr=1 on the next edge.
